l2_bus_arbiter: RTL and testbench
=================================

// Module: l2_bus_arbiter
// PURPOSE
//  Shares the single L2 memory port between the I-cache and D-cache miss handlers.
//  Drives each handler's l2_bus_arbiter_rd_granted / l2_bus_arbiter_wr_granted inputs.
//  Holds a grant for a whole line transfer (burst lock); picks the next owner round-robin.
//  A hold timer forces release when the other side is waiting.
// PARAMETERS
//  ADDR_W    32  L2 address width
//  DATA_W    32  L2 data word width
//  MAX_HOLD  16  max consecutive granted cycles while the other requester waits (>=2)
// PORTS
//  clk                 in   1       clock, rising edge
//  rst_n               in   1       asynchronous reset, active low
//  ic_l2_mem_en        in   1       I-cache request (held for the whole transfer)
//  ic_l2_mem_wr_en     in   1       I-cache request is a write
//  ic_l2_mem_addr      in   ADDR_W  I-cache L2 address
//  ic_l2_mem_wr_data   in   DATA_W  I-cache write data
//  ic_rd_granted       out  1       I-cache owns the bus, read
//  ic_wr_granted       out  1       I-cache owns the bus, write
//  ic_l2_mem_rd_data   out  DATA_W  L2 read data, zero when not owner
//  dc_*                (same 7 signals for the D-cache)
//  l2_mem_en           out  1       muxed L2 enable
//  l2_mem_wr_en        out  1       muxed L2 write enable
//  l2_mem_access_addr  out  ADDR_W  muxed L2 address
//  l2_mem_wr_data      out  DATA_W  muxed L2 write data
//  l2_mem_rd_data      in   DATA_W  L2 read data
//  arb_owner           out  2       00 none, 01 I-cache, 10 D-cache
// BEHAVIOUR
//  - FSM states: IDLE, OWN_IC, OWN_DC. The state and rr_ptr are registered. Grants decode from state.
//  - Reset: state=IDLE, rr_ptr=IC (I-cache wins the first tie), hold_cnt=0.
//    All outputs are 0 while rst_n is low. Reset mid-burst drops the grant at once.
//  - IDLE: one requester -> own it next cycle. Both -> take rr_ptr's side.
//    None -> stay in IDLE. Grant latency: 1 cycle from en to granted.
//  - OWN_x: held while x_l2_mem_en=1.
//    x_rd_granted = ~x_l2_mem_wr_en; x_wr_granted = x_l2_mem_wr_en. Both decode live each cycle.
//  - Release: x_l2_mem_en=0 -> IDLE next cycle. rr_ptr moves to the other side.
//    Always 1 idle bubble between owners (no back-to-back handover).
//  - hold_cnt: cleared on entry to OWN_x. Increments each owned cycle while the other side requests.
//    Saturates at MAX_HOLD-1. At MAX_HOLD-1 with the other side still requesting -> forced IDLE.
//    That side is then granted after the bubble.
//    A preempted requester keeps en high and re-arbitrates normally.
//  - Mux: l2_mem_* come from the owner. In IDLE they are all 0. Owner's rd_data = l2_mem_rd_data.
//    The non-owner's rd_data is 0.
//  - Simultaneous release by the owner and a new request from the same side -> IDLE. rr_ptr favours the other side.
//  - arb_owner is one-hot, or 00. Never 11.
// CONFIGURATION
//  - L2_ARB_DC_PRIO_EN defined: fixed priority; the D-cache wins every tie in IDLE.
//    rr_ptr is unused. The hold timeout preempts only an I-cache owner; a D-cache owner keeps the bus until release.
//  - Undefined: round-robin plus symmetric timeout, as above.
// TESTING
//  - Reset: rst_n=0 -> all grants 0, arb_owner=00, l2_mem_en=0. Release -> IDLE.
//  - Single read: dc_en=1, wr=0, addr=0x1000_0020 held 8 cyc.
//    Next cycle dc_rd_granted=1, l2_mem_access_addr=0x1000_0020, arb_owner=10.
//    Drop en -> grant 0 the next cycle.
//  - Tie: ic_en and dc_en rise in the same cycle after reset -> IC granted first.
//    IC releases -> 1 idle cycle -> DC granted.
//  - Timeout (MAX_HOLD=16): IC holds en for 40 cyc while DC requests.
//    IC is forced off after 16 owned cycles. DC is granted 1 cycle later.
//  - Write mux: dc wr_en=1, wr_data=0xDEAD_BEEF -> dc_wr_granted=1, l2_mem_wr_en=1, l2_mem_wr_data=0xDEAD_BEEF.
//    ic_l2_mem_rd_data=0.
//  - Reset mid-burst: assert rst_n=0 while OWN_DC -> grants 0 asynchronously. After reset, IC wins the tie.

Source files
------------

// File: rtl/l2_bus_arbiter.sv
// Purpose : shares the single L2 memory port between the I-cache and D-cache miss handlers.
// Latency : 1 cycle from *_l2_mem_en to grant, and 1 idle cycle between two owners.
// Backpres: a requester holds *_l2_mem_en until it is granted. If the other side waits,
//           the owner is forced off after MAX_HOLD consecutive owned cycles.
// Config  : `define L2_ARB_DC_PRIO_EN makes the D-cache win every tie. In that build the
//           hold timeout preempts only an I-cache owner. With the macro undefined, ties go
//           round-robin and the timeout applies to both sides.
// Ports   : clk/rst_n (async active-low).
//           ic_*/dc_* : en, wr_en, addr, wr_data in; rd_granted, wr_granted, rd_data out.
//           l2_mem_* : muxed port toward L2.
//           arb_owner : 00 none, 01 I-cache, 10 D-cache.
module l2_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_l2_mem_en,
  input  logic              ic_l2_mem_wr_en,
  input  logic [ADDR_W-1:0] ic_l2_mem_addr,
  input  logic [DATA_W-1:0] ic_l2_mem_wr_data,
  output logic              ic_rd_granted,
  output logic              ic_wr_granted,
  output logic [DATA_W-1:0] ic_l2_mem_rd_data,
  input  logic              dc_l2_mem_en,
  input  logic              dc_l2_mem_wr_en,
  input  logic [ADDR_W-1:0] dc_l2_mem_addr,
  input  logic [DATA_W-1:0] dc_l2_mem_wr_data,
  output logic              dc_rd_granted,
  output logic              dc_wr_granted,
  output logic [DATA_W-1:0] dc_l2_mem_rd_data,
  output logic              l2_mem_en,
  output logic              l2_mem_wr_en,
  output logic [ADDR_W-1:0] l2_mem_access_addr,
  output logic [DATA_W-1:0] l2_mem_wr_data,
  input  logic [DATA_W-1:0] l2_mem_rd_data,
  output logic [1:0]        arb_owner
);

  localparam int               CNT_W    = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  // State encoding doubles as the one-hot arb_owner value.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_IC = 2'b01,
    OWN_DC = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             tie_to_dc;
  logic             dc_timeout_en;

`ifdef L2_ARB_DC_PRIO_EN
  assign tie_to_dc     = 1'b1;
  assign dc_timeout_en = 1'b0;
`else
  // rr_ptr: 0 -> I-cache wins the next tie, 1 -> D-cache wins the next tie.
  logic rr_ptr_q, rr_ptr_d;

  assign tie_to_dc     = rr_ptr_q;
  assign dc_timeout_en = 1'b1;

  // Any exit from an owned state (release or timeout) hands the next tie to the other side.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_d == IDLE) begin
      if (state_q == OWN_IC) begin
        rr_ptr_d = 1'b1;
      end else if (state_q == OWN_DC) begin
        rr_ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Every owned state is entered from IDLE, so clearing the counter in IDLE
  // resets it on entry. The counter saturates at HOLD_LIM. Reaching HOLD_LIM
  // while the other side still requests forces the bus back to IDLE.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (ic_l2_mem_en && dc_l2_mem_en) begin
          state_d = tie_to_dc ? OWN_DC : OWN_IC;
        end else if (ic_l2_mem_en) begin
          state_d = OWN_IC;
        end else if (dc_l2_mem_en) begin
          state_d = OWN_DC;
        end
      end
      OWN_IC: begin
        if (!ic_l2_mem_en) begin
          state_d = IDLE;
        end else if (dc_l2_mem_en) begin
          if (hold_cnt_q == HOLD_LIM) begin
            state_d = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      OWN_DC: begin
        if (!dc_l2_mem_en) begin
          state_d = IDLE;
        end else if (ic_l2_mem_en) begin
          if (hold_cnt_q == HOLD_LIM) begin
            if (dc_timeout_en) begin
              state_d = IDLE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants decode from the registered state. The read/write split follows the owner's
  // live wr_en. Because state_q resets asynchronously, every output drops at reset.
  always_comb begin
    ic_rd_granted      = 1'b0;
    ic_wr_granted      = 1'b0;
    dc_rd_granted      = 1'b0;
    dc_wr_granted      = 1'b0;
    ic_l2_mem_rd_data  = '0;
    dc_l2_mem_rd_data  = '0;
    l2_mem_en          = 1'b0;
    l2_mem_wr_en       = 1'b0;
    l2_mem_access_addr = '0;
    l2_mem_wr_data     = '0;
    unique case (state_q)
      OWN_IC: begin
        ic_rd_granted      = ~ic_l2_mem_wr_en;
        ic_wr_granted      = ic_l2_mem_wr_en;
        ic_l2_mem_rd_data  = l2_mem_rd_data;
        l2_mem_en          = ic_l2_mem_en;
        l2_mem_wr_en       = ic_l2_mem_wr_en;
        l2_mem_access_addr = ic_l2_mem_addr;
        l2_mem_wr_data     = ic_l2_mem_wr_data;
      end
      OWN_DC: begin
        dc_rd_granted      = ~dc_l2_mem_wr_en;
        dc_wr_granted      = dc_l2_mem_wr_en;
        dc_l2_mem_rd_data  = l2_mem_rd_data;
        l2_mem_en          = dc_l2_mem_en;
        l2_mem_wr_en       = dc_l2_mem_wr_en;
        l2_mem_access_addr = dc_l2_mem_addr;
        l2_mem_wr_data     = dc_l2_mem_wr_data;
      end
      default: ;
    endcase
  end

  assign arb_owner = state_q;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Bench for l2_bus_arbiter.
// The table-driven vectors cover reset, single read, write mux, live wr_en decode,
// round-robin and the idle bubble. Hand-written sequences cover the tie after reset,
// the hold timeout on both sides, and reset in the middle of a burst.
module tb_l2_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

`ifdef L2_ARB_DC_PRIO_EN
  localparam bit DC_PRIO = 1'b1;
`else
  localparam bit DC_PRIO = 1'b0;
`endif

  localparam logic [1:0] O_NONE = 2'b00;
  localparam logic [1:0] O_IC   = 2'b01;
  localparam logic [1:0] O_DC   = 2'b10;

  logic              clk;
  logic              rst_n;
  logic              ic_l2_mem_en, ic_l2_mem_wr_en;
  logic [ADDR_W-1:0] ic_l2_mem_addr;
  logic [DATA_W-1:0] ic_l2_mem_wr_data;
  logic              ic_rd_granted, ic_wr_granted;
  logic [DATA_W-1:0] ic_l2_mem_rd_data;
  logic              dc_l2_mem_en, dc_l2_mem_wr_en;
  logic [ADDR_W-1:0] dc_l2_mem_addr;
  logic [DATA_W-1:0] dc_l2_mem_wr_data;
  logic              dc_rd_granted, dc_wr_granted;
  logic [DATA_W-1:0] dc_l2_mem_rd_data;
  logic              l2_mem_en, l2_mem_wr_en;
  logic [ADDR_W-1:0] l2_mem_access_addr;
  logic [DATA_W-1:0] l2_mem_wr_data;
  logic [DATA_W-1:0] l2_mem_rd_data;
  logic [1:0]        arb_owner;

  int total = 0;
  int bad   = 0;

  l2_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ic_l2_mem_en       (ic_l2_mem_en),
    .ic_l2_mem_wr_en    (ic_l2_mem_wr_en),
    .ic_l2_mem_addr     (ic_l2_mem_addr),
    .ic_l2_mem_wr_data  (ic_l2_mem_wr_data),
    .ic_rd_granted      (ic_rd_granted),
    .ic_wr_granted      (ic_wr_granted),
    .ic_l2_mem_rd_data  (ic_l2_mem_rd_data),
    .dc_l2_mem_en       (dc_l2_mem_en),
    .dc_l2_mem_wr_en    (dc_l2_mem_wr_en),
    .dc_l2_mem_addr     (dc_l2_mem_addr),
    .dc_l2_mem_wr_data  (dc_l2_mem_wr_data),
    .dc_rd_granted      (dc_rd_granted),
    .dc_wr_granted      (dc_wr_granted),
    .dc_l2_mem_rd_data  (dc_l2_mem_rd_data),
    .l2_mem_en          (l2_mem_en),
    .l2_mem_wr_en       (l2_mem_wr_en),
    .l2_mem_access_addr (l2_mem_access_addr),
    .l2_mem_wr_data     (l2_mem_wr_data),
    .l2_mem_rd_data     (l2_mem_rd_data),
    .arb_owner          (arb_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst_n;
    logic       ic_en;
    logic       ic_wr;
    logic       dc_en;
    logic       dc_wr;
    logic [1:0] owner;
    logic [3:0] gnt;   // {ic_rd, ic_wr, dc_rd, dc_wr}
  } row_t;

  localparam int NROWS = 32;
  row_t rows [NROWS];

  function automatic row_t mk(input logic r, input logic ie, input logic iw,
                              input logic de, input logic dw,
                              input logic [1:0] o, input logic [3:0] g);
    row_t t;
    t.rst_n = r;  t.ic_en = ie; t.ic_wr = iw;
    t.dc_en = de; t.dc_wr = dw; t.owner = o; t.gnt = g;
    return t;
  endfunction

  function automatic logic [3:0] rdg(input logic [1:0] o);
    if (o == O_IC) return 4'b1000;
    if (o == O_DC) return 4'b0010;
    return 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected mux outputs follow from the expected owner and the inputs the bench drives.
  task automatic check_all(input string tag, input logic [1:0] eo, input logic [3:0] eg);
    logic              e_en, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd, e_icrd, e_dcrd;
    e_en = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0; e_icrd = '0; e_dcrd = '0;
    if (eo == O_IC) begin
      e_en = ic_l2_mem_en; e_wr = ic_l2_mem_wr_en; e_addr = ic_l2_mem_addr;
      e_wd = ic_l2_mem_wr_data; e_icrd = l2_mem_rd_data;
    end else if (eo == O_DC) begin
      e_en = dc_l2_mem_en; e_wr = dc_l2_mem_wr_en; e_addr = dc_l2_mem_addr;
      e_wd = dc_l2_mem_wr_data; e_dcrd = l2_mem_rd_data;
    end
    chk($sformatf("%s.owner", tag), {30'b0, arb_owner}, {30'b0, eo});
    chk($sformatf("%s.grants", tag),
        {28'b0, ic_rd_granted, ic_wr_granted, dc_rd_granted, dc_wr_granted}, {28'b0, eg});
    chk($sformatf("%s.l2_en", tag), {31'b0, l2_mem_en}, {31'b0, e_en});
    chk($sformatf("%s.l2_wr_en", tag), {31'b0, l2_mem_wr_en}, {31'b0, e_wr});
    chk($sformatf("%s.l2_addr", tag), l2_mem_access_addr, e_addr);
    chk($sformatf("%s.l2_wr_data", tag), l2_mem_wr_data, e_wd);
    chk($sformatf("%s.ic_rd_data", tag), ic_l2_mem_rd_data, e_icrd);
    chk($sformatf("%s.dc_rd_data", tag), dc_l2_mem_rd_data, e_dcrd);
  endtask

  // One cycle: check on the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [1:0] eo, input logic [3:0] eg);
    @(negedge clk);
    check_all(tag, eo, eg);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n;
    logic [1:0] first_o, second_o;
    first_o  = DC_PRIO ? O_DC : O_IC;
    second_o = DC_PRIO ? O_IC : O_DC;

    rst_n = 1'b0;
    ic_l2_mem_en = 1'b0; ic_l2_mem_wr_en = 1'b0;
    dc_l2_mem_en = 1'b0; dc_l2_mem_wr_en = 1'b0;
    ic_l2_mem_addr    = 32'h2000_0040; ic_l2_mem_wr_data = 32'h1111_2222;
    dc_l2_mem_addr    = 32'h1000_0020; dc_l2_mem_wr_data = 32'hDEAD_BEEF;
    l2_mem_rd_data    = 32'hCAFE_F00D;

    //                 rst ie iw de dw  owner  {icr,icw,dcr,dcw}
    rows[0]  = mk(1'b0, 1, 0, 1, 0, O_NONE, 4'b0000); // requests ignored in reset
    rows[1]  = mk(1'b1, 0, 0, 0, 0, O_NONE, 4'b0000);
    rows[2]  = mk(1'b1, 0, 0, 1, 0, O_NONE, 4'b0000); // DC read: 1-cycle latency
    for (int i = 3; i <= 9; i++) rows[i] = mk(1'b1, 0, 0, 1, 0, O_DC, 4'b0010);
    rows[10] = mk(1'b1, 0, 0, 0, 0, O_DC,   4'b0010); // en dropped, grant still up
    rows[11] = mk(1'b1, 0, 0, 0, 0, O_NONE, 4'b0000);
    rows[12] = mk(1'b1, 0, 0, 1, 1, O_NONE, 4'b0000); // DC write
    rows[13] = mk(1'b1, 0, 0, 1, 1, O_DC,   4'b0001);
    rows[14] = mk(1'b1, 0, 0, 1, 0, O_DC,   4'b0010); // live wr_en decode
    rows[15] = mk(1'b1, 1, 0, 1, 1, O_DC,   4'b0001); // IC waits, not granted
    rows[16] = mk(1'b1, 1, 0, 0, 1, O_DC,   4'b0001);
    rows[17] = mk(1'b1, 1, 0, 0, 0, O_NONE, 4'b0000); // bubble
    rows[18] = mk(1'b1, 1, 0, 0, 0, O_IC,   4'b1000);
    rows[19] = mk(1'b1, 1, 1, 0, 0, O_IC,   4'b0100);
    rows[20] = mk(1'b1, 0, 1, 0, 0, O_IC,   4'b0100);
    rows[21] = mk(1'b1, 1, 0, 1, 0, O_NONE, 4'b0000); // tie after IC owned -> DC
    rows[22] = mk(1'b1, 1, 0, 1, 0, O_DC,   4'b0010);
    rows[23] = mk(1'b1, 1, 0, 0, 0, O_DC,   4'b0010);
    rows[24] = mk(1'b1, 1, 0, 0, 0, O_NONE, 4'b0000);
    rows[25] = mk(1'b1, 0, 0, 0, 0, O_IC,   4'b1000);
    rows[26] = mk(1'b1, 1, 0, 1, 0, O_NONE, 4'b0000); // IC re-requests, DC wins tie
    rows[27] = mk(1'b1, 1, 0, 1, 0, O_DC,   4'b0010);
    rows[28] = mk(1'b1, 1, 0, 0, 0, O_DC,   4'b0010);
    rows[29] = mk(1'b1, 1, 0, 0, 0, O_NONE, 4'b0000);
    rows[30] = mk(1'b1, 0, 0, 0, 0, O_IC,   4'b1000);
    rows[31] = mk(1'b1, 0, 0, 0, 0, O_NONE, 4'b0000);

    @(posedge clk);
    #1;
    for (int i = 0; i < NROWS; i++) begin
      rst_n           = rows[i].rst_n;
      ic_l2_mem_en    = rows[i].ic_en;
      ic_l2_mem_wr_en = rows[i].ic_wr;
      dc_l2_mem_en    = rows[i].dc_en;
      dc_l2_mem_wr_en = rows[i].dc_wr;
      @(negedge clk);
      check_all($sformatf("row%0d", i), rows[i].owner, rows[i].gnt);
      @(posedge clk);
      #1;
    end

    // Tie right after reset, then the bubble before the second owner.
    rst_n = 1'b0;
    ic_l2_mem_en = 1'b0; ic_l2_mem_wr_en = 1'b0;
    dc_l2_mem_en = 1'b0; dc_l2_mem_wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ic_l2_mem_en = 1'b1; dc_l2_mem_en = 1'b1;
    cyc("tie_req", O_NONE, 4'b0000);
    cyc("tie_first", first_o, rdg(first_o));
    cyc("tie_first_hold", first_o, rdg(first_o));
    if (first_o == O_IC) ic_l2_mem_en = 1'b0; else dc_l2_mem_en = 1'b0;
    cyc("tie_first_rel", first_o, rdg(first_o));
    cyc("tie_bubble", O_NONE, 4'b0000);
    cyc("tie_second", second_o, rdg(second_o));
    ic_l2_mem_en = 1'b0; dc_l2_mem_en = 1'b0;
    cyc("tie_second_rel", second_o, rdg(second_o));
    cyc("tie_idle", O_NONE, 4'b0000);

    // Hold timeout: IC owns while DC waits, forced off after 16 owned cycles.
    ic_l2_mem_en = 1'b1;
    cyc("to_req", O_NONE, 4'b0000);
    dc_l2_mem_en = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (arb_owner != O_IC) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("to_ic_owned_cycles", n, 16);
    check_all("to_bubble", O_NONE, 4'b0000);
    @(posedge clk);
    #1;
    cyc("to_dc_grant", O_DC, 4'b0010);
    n = 1;
    while (n < 24) begin
      @(negedge clk);
      if (arb_owner != O_DC) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("to_dc_owned_cycles", n, DC_PRIO ? 24 : 16);
    chk("to_dc_after", {30'b0, arb_owner}, DC_PRIO ? {30'b0, O_DC} : {30'b0, O_NONE});
    ic_l2_mem_en = 1'b0; dc_l2_mem_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc("to_idle", O_NONE, 4'b0000);

    // Reset in the middle of a DC burst drops the grant without a clock edge.
    dc_l2_mem_en = 1'b1;
    cyc("mb_req", O_NONE, 4'b0000);
    cyc("mb_own", O_DC, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("mb_async", O_NONE, 4'b0000);
    ic_l2_mem_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("mb_idle", O_NONE, 4'b0000);
    cyc("mb_tie", first_o, rdg(first_o));
    ic_l2_mem_en = 1'b0; dc_l2_mem_en = 1'b0;
    cyc("mb_rel", first_o, rdg(first_o));
    cyc("mb_end", O_NONE, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
